regfile_wb_arbiter: RTL and testbench

Write-back arbiter and pending-write scoreboard for the 32x32 register file. Three producers (ALU, load unit, multiply/divide unit) share the register file's single write port. This block picks one producer per cycle and drives a registered `wen`/`waddr`/`datain` triple into the register file. It also tracks which registers have an outstanding write, so decode can stall on RAW hazards.

---
 rtl/regfile_wb_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_rr.sv | 59 +++++
 rtl/regfile_wb_arbiter.sv | 88 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Requester indices, default widths and address/data typedefs.
package regfile_wb_pkg;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int DATA_W  = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;
    localparam int REQ_MDU = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// One-hot grant for write-back requesters: round-robin when
// REGFILE_WB_RR_EN is defined, fixed lowest-index priority otherwise.
module wb_rr_arbiter #(
    parameter int NUM_REQ = regfile_wb_pkg::NUM_REQ
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt
);

`ifdef REGFILE_WB_RR_EN
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic             found;
    int               idx;

    // Search starts at the pointer and wraps; winner+1 becomes next pointer.
    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = PTR_W'((idx + 1) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr <= '0;
        else        ptr <= ptr_nxt;
    end
`else
    logic found;
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst_n;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[k]) begin
                found  = 1'b1;
                gnt[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard for the register file.
// Arbitration policy selected by REGFILE_WB_RR_EN (see wb_rr_arbiter).
module regfile_wb_arbiter #(
    parameter int NUM_REQ = regfile_wb_pkg::NUM_REQ,
    parameter int ADDR_W  = regfile_wb_pkg::ADDR_W,
    parameter int DATA_W  = regfile_wb_pkg::DATA_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      claim_valid,
    input  logic [ADDR_W-1:0]         claim_addr,
    input  logic [ADDR_W-1:0]         rs_addr,
    input  logic [ADDR_W-1:0]         rt_addr,
    output logic                      rs_busy,
    output logic                      rt_busy,
    output logic                      rf_wen,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [DATA_W-1:0]         rf_wdata
);

    localparam int NREG = 1 << ADDR_W;

    logic [NUM_REQ-1:0] gnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;
    logic               xfer;
    logic [NREG-1:0]    busy;
    logic [NREG-1:0]    busy_nxt;

    wb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .gnt   (gnt)
    );

    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // r0 writes are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (xfer) begin
            rf_wen   <= (sel_addr != '0);
            rf_waddr <= sel_addr;
            rf_wdata <= sel_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    // A new claim overrides a clear to the same register.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen)      busy_nxt[rf_waddr]   = 1'b0;
        if (claim_valid) busy_nxt[claim_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    assign rs_busy = busy[rs_addr];
    assign rt_busy = busy[rt_addr];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus
// randomized traffic against a behavioural model of arbitration and scoreboard.
module tb_regfile_wb_arbiter;
    import regfile_wb_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic                      claim_valid = 1'b0;
    reg_addr_t                 claim_addr = '0;
    reg_addr_t                 rs_addr = '0;
    reg_addr_t                 rt_addr = '0;
    logic                      rs_busy, rt_busy, rf_wen;
    reg_addr_t                 rf_waddr;
    reg_data_t                 rf_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_busy;
    logic        m_wen;
    reg_addr_t   m_waddr;
    reg_data_t   m_wdata;
    int          m_ptr;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .claim_valid (claim_valid),
        .claim_addr  (claim_addr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_busy     (rs_busy),
        .rt_busy     (rt_busy),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata)
    );

    // Highest-priority valid index starting from the model pointer.
    function automatic int ref_pick(logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] ref_gnt(logic [NUM_REQ-1:0] v);
        logic [NUM_REQ-1:0] r;
        int g;
        r = '0;
        g = ref_pick(v);
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_req(int i, logic v, reg_addr_t a, reg_data_t d);
        req_valid[i] = v;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic idle();
        req_valid   = '0;
        claim_valid = 1'b0;
        claim_addr  = '0;
    endtask

    task automatic model_reset();
        m_busy  = '0;
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
        m_ptr   = 0;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        int          g;
        logic [31:0] nb;
        reg_addr_t   a;
        g  = ref_pick(req_valid);
        nb = m_busy;
        if (m_wen) nb[m_waddr] = 1'b0;
        if (claim_valid) nb[claim_addr] = 1'b1;
        nb[0] = 1'b0;
        if (g >= 0) begin
            a       = req_addr[g*ADDR_W +: ADDR_W];
            m_wen   = (a != '0);
            m_waddr = a;
            m_wdata = req_data[g*DATA_W +: DATA_W];
`ifdef REGFILE_WB_RR_EN
            m_ptr   = (g + 1) % NUM_REQ;
`endif
        end else begin
            m_wen = 1'b0;
        end
        m_busy = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        claim_valid = 1'b1; claim_addr = 5'd4;
        tick();
        claim_addr = 5'd10;
        set_req(REQ_ALU, 1'b1, 5'd12, 32'hA5A5_0001);
        tick();
        idle();
        rs_addr = 5'd4; rt_addr = 5'd10;
        #1;
        n_checks++;
        if (rs_busy !== 1'b1 || rf_wen !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_state: rs_busy=%b rf_wen=%b required 1 1", rs_busy, rf_wen);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rf_wen !== 1'b0) begin
            n_fail++; $display("FAIL reset_rf_wen: got %b required 0", rf_wen);
        end
        n_checks++;
        if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_fail++; $display("FAIL reset_rf_addr_data: got %0d %h required 0 0", rf_waddr, rf_wdata);
        end
        n_checks++;
        if (rs_busy !== 1'b0 || rt_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got rs=%b rt=%b required 0 0", rs_busy, rt_busy);
        end
        n_checks++;
        if (req_ready !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b required 000", req_ready);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        idle();
        set_req(REQ_ALU, 1'b1, 5'd5, 32'hDEAD_BEEF);
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++; $display("FAIL single_ready: got %b required 001", req_ready);
        end
        tick();
        idle();
        n_checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_write: got wen=%b addr=%0d data=%h required 1 5 deadbeef",
                     rf_wen, rf_waddr, rf_wdata);
        end
        tick();
        n_checks++;
        if (rf_wen !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_idle_hold: got wen=%b addr=%0d data=%h required 0 5 deadbeef",
                     rf_wen, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_contention();
        logic [NUM_REQ-1:0] e;
        do_reset();
        set_req(REQ_ALU, 1'b1, 5'd1, 32'h11);
        set_req(REQ_MEM, 1'b1, 5'd2, 32'h22);
        set_req(REQ_MDU, 1'b1, 5'd3, 32'h33);
        for (int c = 0; c < NUM_REQ; c++) begin
            #1;
            e = '0; e[c] = 1'b1;
            n_checks++;
            if (req_ready !== e) begin
                n_fail++; $display("FAIL contention_grant%0d: got %b required %b", c, req_ready, e);
            end
            tick();
            req_valid[c] = 1'b0;
            n_checks++;
            if (rf_wen !== 1'b1 || rf_waddr !== 5'(c + 1)) begin
                n_fail++;
                $display("FAIL contention_write%0d: got wen=%b addr=%0d required 1 %0d",
                         c, rf_wen, rf_waddr, c + 1);
            end
        end
        set_req(REQ_ALU, 1'b1, 5'd8, 32'h88);
        set_req(REQ_MDU, 1'b1, 5'd9, 32'h99);
        #1;
        n_checks++;
        if (req_ready !== 3'b001) begin
            n_fail++; $display("FAIL contention_regrant_alu: got %b required 001", req_ready);
        end
        tick();
        req_valid[REQ_ALU] = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 3'b100 || rf_waddr !== 5'd8) begin
            n_fail++;
            $display("FAIL contention_regrant_mdu: got %b addr=%0d required 100 8", req_ready, rf_waddr);
        end
        tick();
        idle();
        n_checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin
            n_fail++;
            $display("FAIL contention_last_write: got wen=%b addr=%0d data=%h required 1 9 99",
                     rf_wen, rf_waddr, rf_wdata);
        end
    endtask

    task automatic test_r0();
        idle();
        set_req(REQ_MEM, 1'b1, 5'd0, 32'h1234);
        #1;
        n_checks++;
        if (req_ready !== 3'b010) begin
            n_fail++; $display("FAIL r0_ready: got %b required 010", req_ready);
        end
        tick();
        idle();
        n_checks++;
        if (rf_wen !== 1'b0) begin
            n_fail++; $display("FAIL r0_no_wen: got %b required 0", rf_wen);
        end
        claim_valid = 1'b1; claim_addr = 5'd0;
        tick();
        idle();
        rs_addr = 5'd0;
        #1;
        n_checks++;
        if (rs_busy !== 1'b0) begin
            n_fail++; $display("FAIL r0_claim_busy: got %b required 0", rs_busy);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rs_addr = 5'd7;
        claim_valid = 1'b1; claim_addr = 5'd7;
        #1;
        n_checks++;
        if (rs_busy !== 1'b0) begin
            n_fail++; $display("FAIL sb_before_claim: got %b required 0", rs_busy);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs_busy !== 1'b1) begin
            n_fail++; $display("FAIL sb_after_claim: got %b required 1", rs_busy);
        end
        tick();
        tick();
        set_req(REQ_MDU, 1'b1, 5'd7, 32'h7777);
        #1;
        n_checks++;
        if (req_ready !== 3'b100 || rs_busy !== 1'b1) begin
            n_fail++; $display("FAIL sb_write_cycle: got ready=%b busy=%b required 100 1", req_ready, rs_busy);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rs_busy !== 1'b1 || rf_wen !== 1'b1) begin
            n_fail++; $display("FAIL sb_m_plus_1: got busy=%b wen=%b required 1 1", rs_busy, rf_wen);
        end
        tick();
        #1;
        n_checks++;
        if (rs_busy !== 1'b0) begin
            n_fail++; $display("FAIL sb_m_plus_2: got %b required 0", rs_busy);
        end
    endtask

    task automatic test_collision();
        idle();
        rt_addr = 5'd9;
        claim_valid = 1'b1; claim_addr = 5'd9;
        tick();
        claim_valid = 1'b0;
        set_req(REQ_ALU, 1'b1, 5'd9, 32'h9999);
        tick();
        idle();
        n_checks++;
        if (rf_wen !== 1'b1 || rf_waddr !== 5'd9) begin
            n_fail++; $display("FAIL coll_write: got wen=%b addr=%0d required 1 9", rf_wen, rf_waddr);
        end
        claim_valid = 1'b1; claim_addr = 5'd9;
        tick();
        idle();
        #1;
        n_checks++;
        if (rt_busy !== 1'b1) begin
            n_fail++; $display("FAIL coll_set_wins: got %b required 1", rt_busy);
        end
        tick();
        #1;
        n_checks++;
        if (rt_busy !== 1'b1) begin
            n_fail++; $display("FAIL coll_stays_busy: got %b required 1", rt_busy);
        end
    endtask

    task automatic test_random();
        int g;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i] && ($urandom_range(1, 0) == 1))
                    set_req(i, 1'b1, 5'($urandom), $urandom);
            end
            claim_valid = 1'($urandom_range(1, 0));
            claim_addr  = 5'($urandom);
            rs_addr     = 5'($urandom);
            rt_addr     = 5'($urandom);
            #1;
            n_checks++;
            if (req_ready !== ref_gnt(req_valid)) begin
                n_fail++;
                $display("FAIL rand_grant@%0d: got %b required %b", n, req_ready, ref_gnt(req_valid));
            end
            n_checks++;
            if (rs_busy !== m_busy[rs_addr] || rt_busy !== m_busy[rt_addr]) begin
                n_fail++;
                $display("FAIL rand_lookup@%0d: got %b%b required %b%b",
                         n, rs_busy, rt_busy, m_busy[rs_addr], m_busy[rt_addr]);
            end
            g = ref_pick(req_valid);
            tick();
            if (g >= 0) req_valid[g] = 1'b0;
            n_checks++;
            if (rf_wen !== m_wen || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
                n_fail++;
                $display("FAIL rand_rf@%0d: got %b %0d %h required %b %0d %h",
                         n, rf_wen, rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        do_reset();
        test_reset();
        test_single_write();
        test_contention();
        test_r0();
        test_scoreboard();
        test_collision();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
